// File: rtl/dpa_pkg.sv
// Shared types and helpers for the photo-album scaler data path.
package dpa_pkg;

   localparam int DPA_ADDR_W = 20;
   localparam int DPA_PIX_W  = 24;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      LAT,
      WR,
      DONE
   } dpa_state_e;

   // Horizontal replication factor for signed shift d = src_log2 - fb_log2.
   function automatic int rep_of(input int d);
      return (d < 0) ? (1 << (-d)) : 1;
   endfunction

endpackage

// File: rtl/dpa_scale_addr_gen.sv
// Destination counters plus source/frame-buffer address generation.
module dpa_scale_addr_gen
   import dpa_pkg::*;
#(
   parameter int ADDR_W    = DPA_ADDR_W,
   parameter int FB_LOG2   = 8,
   parameter int MAX_SHIFT = 3,
   parameter int SZ_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld,
   input  logic              inc,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [SZ_W-1:0]   src_log2,
   input  logic [ADDR_W-1:0] fb_base,
   input  logic              hflip,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [MAX_SHIFT:0] rep,
   output logic              frame_wrap
);

   localparam int XW = FB_LOG2 + MAX_SHIFT;
   localparam int RW = MAX_SHIFT + 1;

   logic [ADDR_W-1:0]  src_q;
   logic [ADDR_W-1:0]  fb_q;
   logic [SZ_W-1:0]    log2_q;
   logic               flip_q;
   logic [FB_LOG2-1:0] dx;
   logic [FB_LOG2-1:0] dy;
   logic               wrapped;

   logic [ADDR_W-1:0]  c_src;
   logic [ADDR_W-1:0]  c_fb;
   logic [SZ_W-1:0]    c_log2;
   logic               c_flip;
   logic [FB_LOG2-1:0] cx;
   logic [FB_LOG2-1:0] cy;
   logic               up;
   logic [SZ_W-1:0]    sh;
   logic [XW-1:0]      sx;
   logic [XW-1:0]      sy;
   logic [ADDR_W-1:0]  sxa;
   logic [ADDR_W-1:0]  mask;

   always_ff @(posedge clk) begin
      if (!reset) begin
         src_q   <= '0;
         fb_q    <= '0;
         log2_q  <= '0;
         flip_q  <= 1'b0;
         dx      <= '0;
         dy      <= '0;
         wrapped <= 1'b0;
      end else if (ld) begin
         src_q   <= src_base;
         fb_q    <= fb_base;
         log2_q  <= src_log2;
         flip_q  <= hflip;
         dx      <= '0;
         dy      <= '0;
         wrapped <= 1'b0;
      end else if (inc) begin
         dx <= dx + 1'b1;
         if (&dx) begin
            dy <= dy + 1'b1;
            if (&dy)
               wrapped <= 1'b1;
         end
      end
   end

   // On the accept cycle the live inputs and a zero origin feed the
   // address path, so the first read address is ready on entry to RD.
   always_comb begin
      c_src  = ld ? src_base : src_q;
      c_fb   = ld ? fb_base : fb_q;
      c_log2 = ld ? src_log2 : log2_q;
      c_flip = ld ? hflip : flip_q;
      cx     = ld ? '0 : dx;
      cy     = ld ? '0 : dy;
      up     = int'(c_log2) < FB_LOG2;
      sh     = up ? SZ_W'(FB_LOG2 - int'(c_log2))
                  : SZ_W'(int'(c_log2) - FB_LOG2);
      sx     = up ? (XW'(cx) >> sh) : (XW'(cx) << sh);
      sy     = up ? (XW'(cy) >> sh) : (XW'(cy) << sh);
      mask   = (ADDR_W'(1) << c_log2) - ADDR_W'(1);
      sxa    = ADDR_W'(sx);
      if (c_flip)
         sxa = mask - sxa;
      rd_addr = c_src + (ADDR_W'(sy) << c_log2) + sxa;
      wr_addr = c_fb + (ADDR_W'(cy) << FB_LOG2) + ADDR_W'(cx);
   end

   assign rep        = RW'(rep_of(int'(log2_q) - FB_LOG2));
   assign frame_wrap = wrapped;

endmodule

// File: rtl/dpa_photo_scaler.sv
// Nearest-neighbour photo scaler: source photo -> square frame buffer.
// Optional horizontal mirror via DPA_SCALER_MIRROR_EN (adds hflip port).
module dpa_photo_scaler
   import dpa_pkg::*;
#(
   parameter int ADDR_W    = DPA_ADDR_W,
   parameter int PIX_W     = DPA_PIX_W,
   parameter int FB_LOG2   = 8,
   parameter int MAX_SHIFT = 3,
   parameter int SZ_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [SZ_W-1:0]   src_log2,
   input  logic [ADDR_W-1:0] fb_base,
`ifdef DPA_SCALER_MIRROR_EN
   input  logic              hflip,
`endif
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] im_a,
   input  logic [PIX_W-1:0]  im_q,
   output logic [PIX_W-1:0]  im_d,
   output logic              im_wen
);

   localparam int RW = MAX_SHIFT + 1;

   dpa_state_e        state;
   logic [PIX_W-1:0]  pix;
   logic [RW-1:0]     rcnt;
   logic [RW-1:0]     rep;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic              frame_wrap;
   logic              size_ok;
   logic              ld;
   logic              inc;
   logic              flip;

`ifdef DPA_SCALER_MIRROR_EN
   assign flip = hflip;
`else
   assign flip = 1'b0;
`endif

   assign size_ok = (src_log2 != '0)
                 && (int'(src_log2) >= FB_LOG2 - MAX_SHIFT)
                 && (int'(src_log2) <= FB_LOG2 + MAX_SHIFT);

   assign ld  = (state == IDLE) && start && size_ok;
   // Counters run one write ahead of the registered write address.
   assign inc = (state == LAT) || ((state == WR) && (rcnt != rep));

   dpa_scale_addr_gen #(
      .ADDR_W    (ADDR_W),
      .FB_LOG2   (FB_LOG2),
      .MAX_SHIFT (MAX_SHIFT),
      .SZ_W      (SZ_W)
   ) u_addr (
      .clk        (clk),
      .reset      (reset),
      .ld         (ld),
      .inc        (inc),
      .src_base   (src_base),
      .src_log2   (src_log2),
      .fb_base    (fb_base),
      .hflip      (flip),
      .rd_addr    (rd_addr),
      .wr_addr    (wr_addr),
      .rep        (rep),
      .frame_wrap (frame_wrap)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         im_wen <= 1'b1;
         im_a   <= '0;
         pix    <= '0;
         rcnt   <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (size_ok) begin
                     state  <= RD;
                     busy   <= 1'b1;
                     im_a   <= rd_addr;
                     im_wen <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            RD: state <= LAT;
            LAT: begin
               pix    <= im_q;
               state  <= WR;
               im_a   <= wr_addr;
               im_wen <= 1'b0;
               rcnt   <= RW'(1);
            end
            WR: begin
               if (rcnt == rep) begin
                  im_wen <= 1'b1;
                  if (frame_wrap) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= RD;
                     im_a  <= rd_addr;
                  end
               end else begin
                  rcnt <= rcnt + RW'(1);
                  im_a <= wr_addr;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign im_d = pix;

endmodule

// File: tb/tb_dpa_photo_scaler.sv
// Randomised bench for dpa_photo_scaler against an arithmetic frame model.
module tb_dpa_photo_scaler;

   localparam int ADDR_W    = 20;
   localparam int PIX_W     = 24;
   localparam int FB_LOG2   = 4;
   localparam int MAX_SHIFT = 3;
   localparam int SZ_W      = 4;
   localparam int F         = 1 << FB_LOG2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] src_base = '0;
   logic [SZ_W-1:0]   src_log2 = '0;
   logic [ADDR_W-1:0] fb_base = '0;
`ifdef DPA_SCALER_MIRROR_EN
   logic              hflip = 1'b0;
`endif
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] im_a;
   logic [PIX_W-1:0]  im_q = '0;
   logic [PIX_W-1:0]  im_d;
   logic              im_wen;

   int n_chk = 0;
   int n_err = 0;

   logic [PIX_W-1:0]  fbm [int];
   int                nwr = 0;
   int                rd_bad = 0;
   logic [ADDR_W-1:0] cur_base = '0;
   int                cur_area = 0;
   logic [ADDR_W-1:0] rd_off;

   always #5 clk = ~clk;

   dpa_photo_scaler #(
      .ADDR_W    (ADDR_W),
      .PIX_W     (PIX_W),
      .FB_LOG2   (FB_LOG2),
      .MAX_SHIFT (MAX_SHIFT),
      .SZ_W      (SZ_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .src_base (src_base),
      .src_log2 (src_log2),
      .fb_base  (fb_base),
`ifdef DPA_SCALER_MIRROR_EN
      .hflip    (hflip),
`endif
      .busy     (busy),
      .done     (done),
      .err      (err),
      .im_a     (im_a),
      .im_q     (im_q),
      .im_d     (im_d),
      .im_wen   (im_wen)
   );

   function automatic logic [PIX_W-1:0] src_pix(input logic [ADDR_W-1:0] a);
      logic [31:0] h;
      h = {12'h0, a} * 32'h9E3779B1;
      return h[31:8];
   endfunction

   // Synchronous single-port image memory; source content is a hash of address.
   always @(posedge clk) begin
      if (im_wen === 1'b0) begin
         fbm[int'(im_a)] = im_d;
         nwr++;
      end else begin
         im_q <= src_pix(im_a);
      end
      if (busy === 1'b1 && im_wen === 1'b1) begin
         rd_off = im_a - cur_base;
         if (int'(rd_off) >= cur_area)
            rd_bad++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic run_copy(input logic [ADDR_W-1:0] base, input int lg,
                           input logic [ADDR_W-1:0] fbb, input bit fl,
                           input bit poke);
      bit                ok;
      int                s, rep, total, cyc, sx, sy;
      bit                err_seen;
      logic [ADDR_W-1:0] ra, wa;
      logic [PIX_W-1:0]  got;
      ok = (lg >= 1) && (lg >= FB_LOG2 - MAX_SHIFT) && (lg <= FB_LOG2 + MAX_SHIFT);
      s = 1 << lg;
      rep = (lg < FB_LOG2) ? (1 << (FB_LOG2 - lg)) : 1;
      total = (F * F / rep) * (2 + rep) + 2;
      fbm.delete();
      nwr = 0;
      rd_bad = 0;
      cur_base = base;
      cur_area = ok ? (1 << (2 * lg)) : 0;
      err_seen = 0;
      @(negedge clk);
      src_base = base;
      src_log2 = SZ_W'(lg);
      fb_base = fbb;
`ifdef DPA_SCALER_MIRROR_EN
      hflip = fl;
`endif
      start = 1'b1;
      cyc = 1;
      @(negedge clk);
      start = 1'b0;
      cyc = 2;
      src_base = ADDR_W'($urandom);
      src_log2 = SZ_W'($urandom);
      fb_base = ADDR_W'($urandom);
`ifdef DPA_SCALER_MIRROR_EN
      hflip = 1'($urandom);
`endif
      if (!ok) begin
         check_eq("rej_err", 32'(err), 1);
         check_eq("rej_busy", 32'(busy), 0);
         check_eq("rej_wen", 32'(im_wen), 1);
         repeat (4) @(negedge clk);
         check_eq("rej_err_clr", 32'(err), 0);
         check_eq("rej_busy2", 32'(busy), 0);
         check_eq("rej_nwr", nwr, 0);
         return;
      end
      check_eq("acc_err", 32'(err), 0);
      check_eq("acc_busy", 32'(busy), 1);
      while (done !== 1'b1 && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         start = poke && (cyc == 12);
         if (start)
            src_log2 = 4'd15;
         if (err === 1'b1)
            err_seen = 1;
      end
      start = 1'b0;
      check_eq("done_cycle", cyc, total);
      check_eq("done_busy", 32'(busy), 0);
      check_eq("busy_err", 32'(err_seen), 0);
      @(negedge clk);
      check_eq("done_pulse", 32'(done), 0);
      check_eq("n_writes", nwr, F * F);
      check_eq("n_addrs", fbm.num(), F * F);
      check_eq("rd_range", rd_bad, 0);
      for (int y = 0; y < F; y++) begin
         for (int x = 0; x < F; x++) begin
            sy = y * s / F;
            sx = x * s / F;
            if (fl)
               sx = s - 1 - sx;
            ra = base + ADDR_W'(sy * s + sx);
            wa = fbb + ADDR_W'(y * F + x);
            got = fbm.exists(int'(wa)) ? fbm[int'(wa)] : '1;
            check_eq($sformatf("pix_%0d_%0d", x, y), 32'(got), 32'(src_pix(ra)));
         end
      end
   endtask

   task automatic rand_flip(output bit fl);
`ifdef DPA_SCALER_MIRROR_EN
      fl = 1'($urandom);
`else
      fl = 1'b0;
`endif
   endtask

   initial begin
      int k, snap;
      bit fl;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_err", 32'(err), 0);
      check_eq("rst_wen", 32'(im_wen), 1);
      check_eq("rst_a", 32'(im_a), 0);
      check_eq("rst_d", 32'(im_d), 0);
      reset = 1'b1;

      run_copy(20'h10000, FB_LOG2 - 1, 20'h00000, 1'b0, 1'b0);
      run_copy(20'h20000, FB_LOG2 + 1, 20'h00000, 1'b0, 1'b0);
      run_copy(20'h30000, FB_LOG2, 20'h01000, 1'b0, 1'b0);
      run_copy(20'h40000, FB_LOG2 + 4, 20'h00000, 1'b0, 1'b0);
      run_copy(20'h40000, 0, 20'h00000, 1'b0, 1'b0);
      run_copy(20'h50000, FB_LOG2 - MAX_SHIFT, 20'h02000, 1'b0, 1'b0);
      run_copy(20'hFFFF0, FB_LOG2 + MAX_SHIFT, 20'hFFF80, 1'b0, 1'b1);

      // Abort mid-copy at the first write of row 10, then restart cleanly.
      cur_base = 20'h60000;
      cur_area = 1 << (2 * (FB_LOG2 - 1));
      rd_bad = 0;
      @(negedge clk);
      src_base = 20'h60000;
      src_log2 = SZ_W'(FB_LOG2 - 1);
      fb_base = 20'h00400;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(im_wen === 1'b0 && im_a === 20'h00400 + 20'(10 * F)) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check_eq("dy10_seen", 32'(k < 3000), 1);
      reset = 1'b0;
      @(negedge clk);
      check_eq("abort_busy", 32'(busy), 0);
      check_eq("abort_wen", 32'(im_wen), 1);
      check_eq("abort_done", 32'(done), 0);
      snap = nwr;
      repeat (3) @(negedge clk);
      check_eq("abort_nwr", nwr, snap);
      reset = 1'b1;
      run_copy(20'h60000, FB_LOG2 - 1, 20'h00400, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         rand_flip(fl);
         run_copy(ADDR_W'($urandom), int'($urandom_range(FB_LOG2 + MAX_SHIFT, 1)),
                  ADDR_W'($urandom), fl, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dpa_photo_scaler.md
Name: dpa_photo_scaler

Overview:
- Parametrised successor to the photo-album data path's fixed-size expand logic.
- Copies one square source photo of any power-of-two size (2^src_log2 per side) from image memory into a square frame buffer of 2^FB_LOG2 per side.
- Uses nearest-neighbour pixel replication for upscaling and stride subsampling for downscaling.
- Sits between the album controller (which issues start/base addresses) and the shared single-port image memory.

Parameters:
- ADDR_W, 20, image memory address width
- PIX_W, 24, pixel width (packed RGB)
- FB_LOG2, 8, log2 of frame-buffer side (256x256 default)
- MAX_SHIFT, 3, maximum |src_log2 - FB_LOG2| accepted
- SZ_W, 4, width of the src_log2 input

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_base  in  ADDR_W  first address of source photo (row-major)
- src_log2  in  SZ_W  log2 of source side
- fb_base  in  ADDR_W  first address of frame buffer
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last write
- err  out  1  one-cycle pulse when start is rejected (size out of range)
- im_a  out  ADDR_W  image memory address
- im_q  in  PIX_W  read data, valid one cycle after a read address is presented
- im_d  out  PIX_W  write data
- im_wen  out  1  active-low write enable

Behaviour:
- Reset (reset=0 at a clock edge): state IDLE; busy=0, done=0, err=0, im_wen=1, im_a=0, im_d=0; x/y counters and the pixel latch cleared. Reset mid-copy aborts immediately; no further writes.
- Definitions: d = src_log2 - FB_LOG2 (signed); up = (d<0), sh = |d|, rep = up ? 2^sh : 1.
- Range check: src_log2 must lie in [FB_LOG2-MAX_SHIFT, FB_LOG2+MAX_SHIFT] and be >=1.
  - Out-of-range start -> err=1 for one cycle; stay in IDLE; no memory access.
- Dest counters: dx, dy, each FB_LOG2 bits.
- Source coordinates: sx = up ? dx>>sh : dx<<sh; sy likewise from dy.
- Addresses, all modulo 2^ADDR_W (wrap silently):
  - read address = src_base + (sy<<src_log2) + sx
  - write address = fb_base + (dy<<FB_LOG2) + dx
- FSM:
  - IDLE: on valid start, latch inputs; dx=dy=0 -> RD.
  - RD: im_a=read addr, im_wen=1 -> LAT.
  - LAT: capture im_q into pixel latch -> WR.
  - WR: im_a=write addr, im_d=latch, im_wen=0.
    - Each cycle dx++; stay in WR for rep consecutive cycles, so one source read feeds rep horizontal writes.
    - After the rep-th write: if dx wrapped to 0, dy++.
    - If dy wrapped -> DONE, else -> RD.
  - DONE: done=1, busy=0 next cycle -> IDLE.
- Vertical replication in upscale mode comes from re-reading the same source row for each dy sharing sy. No line buffer.
- Cycle counts (default params):
  - Per source read: 2 + rep cycles.
  - Total = (2^(2*FB_LOG2)/rep)*(2+rep) + 1 (DONE) + 1 (accept).
- im_wen=0 only in WR. start while busy is ignored (no err).
- Inputs are latched at accept; later changes have no effect until the next start.

Optional Feature:
- Macro DPA_SCALER_MIRROR_EN.
- When defined: extra input port hflip (1 bit), latched at start. When latched high, sx is replaced by (2^src_log2 - 1 - sx), giving a horizontally mirrored output. Cycle timing is unchanged.
- When undefined: no hflip port; behaviour as above.

Decomposition:
- Package dpa_pkg holds:
  - state enum (IDLE, RD, LAT, WR, DONE)
  - default ADDR_W/PIX_W constants
  - a function computing rep from the signed shift
- One natural sub-module: dpa_scale_addr_gen. It is combinational plus the dx/dy counters: it produces read/write addresses and the row/frame wrap flags. The top holds the FSM and the pixel latch.

Test Plan:
- src_log2=7, src_base=0x10000, fb_base=0x00000 -> each source pixel (i,j) appears at fb (2i..2i+1, 2j..2j+1); 65536 writes; done at cycle 131074 after start.
- src_log2=9, src_base=0x20000 -> fb(x,y)=src(2x,2y); 65536 writes; 196610 cycles; no read address outside src_base+0..0x3FFFF.
- src_log2=8 -> 1:1 copy; memory compare exact.
- src_log2=12 (shift 4) -> err pulse, busy stays 0, im_wen stays 1.
- reset=0 asserted during WR at dy=10 -> next cycle IDLE, im_wen=1, busy=0; new start restarts from dx=dy=0.
- fb_base=0xFFF00 -> write addresses wrap to 0x00000 onward; start pulse while busy -> ignored.
